// File: rtl/pe_pkg.sv
// Shared PE definitions: element size defaults, serializer state encoding and
// the drain-position to element-index mapping used by the vector serializer.
package pe_pkg;

    localparam int PE_WIDTH = 8;
    localparam int PE_DEPTH = 32;

    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_t;

    // Descending order walks down from the last valid element.
    function automatic int ser_elem_idx(input int pos, input int len, input logic dir);
        return dir ? (len - 1 - pos) : pos;
    endfunction

endpackage

// File: rtl/pe_lane_select.sv
// One output lane of the serializer: maps (beat, length, direction) to the
// stored element this lane carries, and zero-fills lanes past the vector end.
module pe_lane_select
    import pe_pkg::*;
#(
    parameter int WIDTH  = PE_WIDTH,
    parameter int DEPTH  = PE_DEPTH,
    parameter int LANES  = 1,
    parameter int LANE   = 0,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH + 1),
    parameter int BEAT_W = $clog2(DEPTH / LANES) + 1
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] i_src,
    input  logic [BEAT_W-1:0]           i_beat,
    input  logic [LEN_W-1:0]            i_len,
    input  logic                        i_dir,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_mask
);

    int               w_pos;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        w_pos  = int'(i_beat) * LANES + LANE;
        o_mask = w_pos < int'(i_len);
        w_sel  = IDX_W'(ser_elem_idx(w_pos, int'(i_len), i_dir));
        o_data = o_mask ? i_src[w_sel] : '0;
    end

endmodule

// File: rtl/pe_vector_serializer.sv
// Parallel-load, serial-drain vector buffer: captures DEPTH elements in one
// handshake and streams them LANES per beat with valid/ready flow control.
module pe_vector_serializer
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int DEPTH = PE_DEPTH,
    parameter int LANES = 1,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_load_valid,
    output logic                     o_load_ready,
    input  logic [DEPTH*WIDTH-1:0]   i_load_data,
    input  logic [LEN_W-1:0]         i_load_len,
    input  logic                     i_load_dir,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [LANES*WIDTH-1:0]   o_out_data,
    output logic [LANES-1:0]         o_out_mask,
    output logic [IDX_W-1:0]         o_out_idx,
    output logic                     o_out_last
);

    localparam int BEAT_W = $clog2(DEPTH / LANES) + 1;

    ser_state_t                  r_state, w_state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [LEN_W-1:0]            r_len;
    logic                        r_dir;
    logic [BEAT_W-1:0]           r_beat;

    logic                        r_out_valid;
    logic [LANES-1:0][WIDTH-1:0] r_out_data;
    logic [LANES-1:0]            r_out_mask;
    logic [IDX_W-1:0]            r_out_idx;
    logic                        r_out_last;

    logic                        w_take, w_load_ready, w_load_fire;
    logic                        w_adv, w_clr;
    logic [LEN_W-1:0]            w_len_clamp, w_nxt_len;
    logic                        w_nxt_dir, w_nxt_last;
    logic [BEAT_W-1:0]           w_nxt_beat;
    logic [IDX_W-1:0]            w_nxt_idx;
    logic [DEPTH-1:0][WIDTH-1:0] w_nxt_src;
    logic [LANES-1:0][WIDTH-1:0] w_lane_data;
    logic [LANES-1:0]            w_lane_mask;

    assign w_take       = r_out_valid && i_out_ready;
    assign w_load_ready = (r_state == SER_IDLE) || (w_take && r_out_last);
    assign w_load_fire  = i_load_valid && w_load_ready;
    assign w_len_clamp  = (int'(i_load_len) > DEPTH) ? LEN_W'(DEPTH) : i_load_len;

    // The beat registered next comes straight from the bus on a load, so beat 0
    // appears right after the accepting edge with no extra stage.
    assign w_nxt_src  = w_load_fire ? i_load_data : r_mem;
    assign w_nxt_len  = w_load_fire ? w_len_clamp : r_len;
    assign w_nxt_dir  = w_load_fire ? i_load_dir  : r_dir;
    assign w_nxt_beat = w_load_fire ? '0 : r_beat + BEAT_W'(1);
    assign w_nxt_last = (int'(w_nxt_beat) + 1) * LANES >= int'(w_nxt_len);
    assign w_nxt_idx  = IDX_W'(ser_elem_idx(int'(w_nxt_beat) * LANES, int'(w_nxt_len), w_nxt_dir));

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pe_lane_select #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .LANES (LANES),
            .LANE  (k),
            .IDX_W (IDX_W),
            .LEN_W (LEN_W),
            .BEAT_W(BEAT_W)
        ) u_sel (
            .i_src (w_nxt_src),
            .i_beat(w_nxt_beat),
            .i_len (w_nxt_len),
            .i_dir (w_nxt_dir),
            .o_data(w_lane_data[k]),
            .o_mask(w_lane_mask[k])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (w_load_fire && (w_len_clamp != '0)) begin
                    w_state_nxt = SER_STREAM;
                    w_adv       = 1'b1;
                end
            end
            SER_STREAM: begin
                if (w_take) begin
                    if (!r_out_last) begin
                        w_adv = 1'b1;
                    end else if (w_load_fire && (w_len_clamp != '0)) begin
                        w_adv = 1'b1;
                    end else begin
                        w_state_nxt = SER_IDLE;
                        w_clr       = 1'b1;
                    end
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= SER_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Storage is only meaningful while streaming, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_load_fire) begin
            r_mem <= i_load_data;
            r_len <= w_len_clamp;
            r_dir <= i_load_dir;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_beat      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_beat      <= w_nxt_beat;
            r_out_valid <= 1'b1;
            r_out_data  <= w_lane_data;
            r_out_mask  <= w_lane_mask;
            r_out_idx   <= w_nxt_idx;
            r_out_last  <= w_nxt_last;
        end else if (w_clr) begin
            r_beat      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end
    end

    assign o_load_ready = w_load_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_mask   = r_out_mask;
    assign o_out_idx    = r_out_idx;
    assign o_out_last   = r_out_last;

endmodule

// File: tb/tb_pe_vector_serializer.sv
// Directed bench for pe_vector_serializer: a single-lane and a four-lane
// instance share clock, reset and flow control; expectations are hand-derived.
module tb_pe_vector_serializer;

    localparam int W = 8;
    localparam int D = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           lv1, lv4, lr1, lr4, dir, rdy;
    logic [5:0]     len;
    logic [D*W-1:0] d1, d4;
    logic           v1, v4, last1, last4, m1;
    logic [7:0]     data1;
    logic [31:0]    data4;
    logic [3:0]     m4;
    logic [4:0]     idx1, idx4;

    int total = 0;
    int bad   = 0;

    pe_vector_serializer #(.WIDTH(W), .DEPTH(D), .LANES(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_load_valid(lv1), .o_load_ready(lr1),
        .i_load_data(d1), .i_load_len(len), .i_load_dir(dir),
        .o_out_valid(v1), .i_out_ready(rdy), .o_out_data(data1),
        .o_out_mask(m1), .o_out_idx(idx1), .o_out_last(last1)
    );

    pe_vector_serializer #(.WIDTH(W), .DEPTH(D), .LANES(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_load_valid(lv4), .o_load_ready(lr4),
        .i_load_data(d4), .i_load_len(len), .i_load_dir(dir),
        .o_out_valid(v4), .i_out_ready(rdy), .o_out_data(data4),
        .o_out_mask(m4), .o_out_idx(idx4), .o_out_last(last4)
    );

    typedef struct {
        logic        ld;
        logic [5:0]  len;
        logic        dir;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [4:0]  idx;
        logic        last;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Single-lane ascending beat whose element value equals its index.
    task automatic chk_b1(input string nm, input int b, input int lb);
        chk(nm, {v1, m1, last1, idx1, data1}, {1'b1, 1'b1, (b == lb), 5'(b), 8'(b)});
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic load1(input logic [5:0] l, input logic dr);
        lv1 = 1'b1; len = l; dir = dr;
        @(posedge clk); #1 lv1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic load4(input logic [5:0] l, input logic dr);
        lv4 = 1'b1; len = l; dir = dr;
        @(posedge clk); #1 lv4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, lastidx;
        rst_n = 1'b1; lv1 = 1'b0; lv4 = 1'b0; dir = 1'b0; len = '0; rdy = 1'b1;
        d1 = '0; d4 = '0;
        #1 rst_n = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_outs1", {v1, m1, last1, idx1, data1}, '0);
        chk("rst_outs4", {v4, m4, last4, idx4, data4}, '0);
        chk("rst_ready", {lr1, lr4}, 2'b11);
        lv1 = 1'b1; len = 6'd4;
        @(negedge clk); lv1 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_load_ignored", v1, 1'b0);

        // Ascending, full length
        for (int i = 0; i < D; i++) d1[i*W +: W] = 8'(i);
        load1(6'd32, 1'b0);
        for (int b = 0; b < D; b++) begin chk_b1("asc", b, D - 1); @(negedge clk); end
        chk("asc_done", {v1, lr1}, 2'b01);

        // Descending with a negative element 0
        d1[7:0] = 8'h80;
        load1(6'd32, 1'b1);
        for (int b = 0; b < D; b++) begin
            chk("desc", {v1, m1, last1, idx1, data1},
                {1'b1, 1'b1, (b == 31), 5'(31 - b), (b == 31) ? 8'h80 : 8'(31 - b)});
            @(negedge clk);
        end
        chk("desc_done", v1, 1'b0);
        d1[7:0] = 8'h00;

        // Backpressure on beat 5
        load1(6'd32, 1'b0);
        for (int b = 0; b <= 5; b++) begin
            chk_b1("bp", b, 31);
            if (b < 5) @(negedge clk);
        end
        rdy = 1'b0;
        repeat (3) begin @(negedge clk); chk_b1("bp_hold", 5, 31); end
        rdy = 1'b1;
        @(negedge clk);
        for (int b = 6; b < D; b++) begin chk_b1("bp_resume", b, 31); @(negedge clk); end
        chk("bp_done", v1, 1'b0);

        // Back-to-back; the bus changes after the first acceptance
        load1(6'd4, 1'b0);
        for (int i = 0; i < D; i++) d1[i*W +: W] = 8'(100 + i);
        for (int b = 0; b < 3; b++) begin chk_b1("b2b_first", b, 3); @(negedge clk); end
        chk_b1("b2b_first", 3, 3);
        lv1 = 1'b1; len = 6'd4; dir = 1'b0;
        #1 chk("b2b_ready", lr1, 1'b1);
        @(posedge clk); #1 lv1 = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            chk("b2b_second", {v1, m1, last1, idx1, data1},
                {1'b1, 1'b1, (b == 3), 5'(b), 8'(100 + b)});
            @(negedge clk);
        end
        chk("b2b_done", v1, 1'b0);

        // Zero length is accepted and dropped
        load1(6'd0, 1'b0);
        chk("zero_len", {v1, lr1}, 2'b01);

        // Oversized length clamps to DEPTH
        for (int i = 0; i < D; i++) d1[i*W +: W] = 8'(i);
        load1(6'd40, 1'b0);
        n = 0; lastidx = -1;
        for (int c = 0; c < 64; c++) begin
            if (!v1) break;
            n++;
            if (last1) lastidx = int'(idx1);
            @(negedge clk);
        end
        chk("clamp_beats", n, 32);
        chk("clamp_last_idx", lastidx, 31);

        // Asynchronous reset in the middle of a vector
        load1(6'd32, 1'b0);
        for (int b = 0; b <= 10; b++) begin
            chk_b1("pre_rst", b, 31);
            if (b < 10) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {v1, m1, last1, idx1, data1}, '0);
        chk("rst_async_ready", lr1, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", v1, 1'b0);
        load1(6'd32, 1'b0);
        for (int b = 0; b < 2; b++) begin chk_b1("post_rst", b, 31); @(negedge clk); end
        repeat (30) @(negedge clk);
        chk("post_rst_done", v1, 1'b0);

        // Four lanes, element i = 0x10+i
        for (int i = 0; i < D; i++) d4[i*W +: W] = 8'(16 + i);
        tbl[0] = '{1'b1, 6'd6, 1'b0, 32'h13121110, 4'hf, 5'd0, 1'b0};
        tbl[1] = '{1'b0, 6'd0, 1'b0, 32'h00001514, 4'h3, 5'd4, 1'b1};
        tbl[2] = '{1'b1, 6'd6, 1'b1, 32'h12131415, 4'hf, 5'd5, 1'b0};
        tbl[3] = '{1'b0, 6'd0, 1'b0, 32'h00001011, 4'h3, 5'd1, 1'b1};
        tbl[4] = '{1'b1, 6'd8, 1'b1, 32'h14151617, 4'hf, 5'd7, 1'b0};
        tbl[5] = '{1'b0, 6'd0, 1'b0, 32'h10111213, 4'hf, 5'd3, 1'b1};
        tbl[6] = '{1'b1, 6'd1, 1'b0, 32'h00000010, 4'h1, 5'd0, 1'b1};
        tbl[7] = '{1'b1, 6'd3, 1'b1, 32'h00101112, 4'h7, 5'd2, 1'b1};
        for (int t = 0; t < 8; t++) begin
            if (tbl[t].ld) load4(tbl[t].len, tbl[t].dir);
            else           @(negedge clk);
            chk($sformatf("lanes4[%0d]", t), {v4, m4, last4, idx4, data4},
                {1'b1, tbl[t].mask, tbl[t].last, tbl[t].idx, tbl[t].data});
        end
        @(negedge clk);
        chk("lanes4_done", v4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_vector_serializer.md
# pe_vector_serializer

Parametrised parallel-load, serial-drain vector buffer for the PE datapath. Captures a whole vector of `DEPTH` signed elements in one handshake, then streams it out `LANES` elements per beat under valid/ready flow control. It supports ascending or descending drain order, a runtime vector length with lane masking, and back-to-back loads with no bubble. It sits between the vector producer (weights/activations) and the PE MAC lanes.

## Interface
- `WIDTH`, 8: element width in bits; elements are two's-complement signed.
- `DEPTH`, 32: maximum elements per vector, ≥2.
- `LANES`, 1: elements emitted per beat, ≥1; `DEPTH % LANES == 0`.
- `IDX_W`, derived `$clog2(DEPTH)`: index width. `LEN_W`, derived `$clog2(DEPTH+1)`: length width.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); asserts immediately, releases synchronously with `clk`.
- `load_valid`  in  1  producer offers a vector.
- `load_ready`  out  1  block accepts a vector this cycle.
- `load_data`  in  DEPTH*WIDTH  element i at bits [i*WIDTH +: WIDTH].
- `load_len`  in  LEN_W  number of valid elements; values above DEPTH are clamped to DEPTH.
- `load_dir`  in  1  drain order: 0 = index 0 first, 1 = index len-1 first.
- `out_valid`  out  1  beat present.
- `out_ready`  in  1  consumer takes beat.
- `out_data`  out  LANES*WIDTH  lane k at [k*WIDTH +: WIDTH], signed.
- `out_mask`  out  LANES  lane k holds a real element.
- `out_idx`  out  IDX_W  element index carried by lane 0.
- `out_last`  out  1  final beat of the vector.

## Operation
- States: IDLE (no vector held) and STREAM (beats pending).
- Load fires on `load_valid && load_ready`. The block captures `load_data`, clamped length L, and direction into storage.
- `load_ready = (state==IDLE) || (out_valid && out_ready && out_last)`. This is combinational, with no dependency on `load_valid`.
- L = 0: load is accepted and discarded. No beats are produced and the state stays IDLE.
- Beats per vector = ceil(L/LANES).
- Ascending order: beat b, lane k carries element b*LANES+k.
- Descending order: beat b, lane k carries element (L-1)-(b*LANES+k).
- `out_idx` is the element index of lane 0.
- A lane whose position b*LANES+k ≥ L has its mask bit at 0 and its data forced to 0.
- Beat advances on `out_valid && out_ready`.
- On the final beat: if a load fires in the same cycle, the new vector's beat 0 is presented next cycle. Otherwise the state returns to IDLE and `out_valid` drops.
- Data is passed through unmodified. No arithmetic is applied to elements, and sign is preserved. The beat counter is log2(DEPTH/LANES)+1 bits and never wraps.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_mask`=0, `out_idx`=0, `out_last`=0, state IDLE. Storage does not need to be cleared.
- `load_ready`=1 once in IDLE, including during reset. Loads presented while `reset`=0 are ignored.
- Latency: a load accepted at edge N presents beat 0 immediately after edge N. Outputs are registered.
- Under backpressure (`out_valid && !out_ready`), every `out_*` signal is held stable until the beat is taken.
- `load_data` changes after acceptance have no effect on the vector in flight.
- Reset mid-stream aborts the vector. Outputs go to reset values asynchronously, and the remaining elements are lost.
- Throughput: one beat per cycle when `out_ready`=1, with zero bubble between vectors.

## Structure
- Shared package `pe_pkg`: state enum `ser_state_t {SER_IDLE, SER_STREAM}`, plus default WIDTH/DEPTH constants shared with the PE.
- A sub-module is natural: `pe_lane_select`. It is combinational and computes per-lane element index, mask and zero-fill from (beat, L, dir).
- The top level holds storage, FSM, beat counter and output registers.

## Test plan
- WIDTH=8, DEPTH=32, LANES=1; element i = i, L=32, dir=0, `out_ready`=1 → 32 beats with data 0..31 and idx 0..31; `out_last` only on data 31; `out_valid` low the following cycle.
- Same load with dir=1 and element 0 = -128 → data 31,30,…,1,-128, idx 31..0, `out_last` on idx 0.
- LANES=4, L=6, dir=0 → beat0 data {0,1,2,3} mask 1111; beat1 data {4,5,0,0} mask 0011 with `out_last`. dir=1 → beat0 {5,4,3,2}, beat1 {1,0,0,0} mask 0011.
- Backpressure: drop `out_ready` for 3 cycles while beat 5 is presented → data 5, idx 5, valid held unchanged, then resume at 6.
- Back-to-back: second load (element i = 100+i) offered during the last beat → `load_ready`=1 that cycle, next cycle beat data 100, no gap. L=0 load → accepted, no `out_valid`. L=40 → clamped, 32 beats.
- Assert reset during beat 10 → all outputs 0 in the same cycle. After release, `load_ready`=1 and a fresh load streams from beat 0.
